// File: rtl/miter_pkg.sv
// Shared types and defaults for the gold-vs-gate sequential miter checker.
// No logic; latency and backpressure not applicable.
// Consumers import this package for the FSM encoding and parameter defaults.
package miter_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/miter_seq_checker_if.sv
// Sample stream in, run status and capture results out.
// Pure wiring, no latency; no backpressure (checker accepts every valid sample).
// master drives samples/start, slave is the checker.
interface miter_seq_checker_if import miter_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             start;
  logic             valid;
  logic [WIDTH-1:0] in_gold;
  logic [WIDTH-1:0] in_gate;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [CNT_W-1:0] mismatch_count;
  logic [CNT_W-1:0] first_fail_idx;
  logic [WIDTH-1:0] first_fail_mask;

  modport master (
    output start, valid, in_gold, in_gate,
    input  busy, done, pass, fail, mismatch_count, first_fail_idx, first_fail_mask
  );

  modport slave (
    input  start, valid, in_gold, in_gate,
    output busy, done, pass, fail, mismatch_count, first_fail_idx, first_fail_mask
  );

endinterface

// File: rtl/miter_cmp_vec.sv
// X-tolerant per-bit compare of a gold/gate match-point vector.
// Combinational, zero latency; no backpressure.
// A gold bit at X is a don't-care; a known gold bit must equal gate exactly (4-state).
module miter_cmp_vec import miter_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] gold,
  input  logic [WIDTH-1:0] gate,
  output logic [WIDTH-1:0] mask,
  output logic             any_mm
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask[i] = (gold[i] !== 1'bx) && (gold[i] !== gate[i]);
    end
  end

  assign any_mm = |mask;

endmodule

// File: rtl/miter_seq_checker.sv
// Checks DEPTH valid gold/gate samples per run; counts and captures the first mismatch.
// done rises one cycle after the last sample is consumed.
// No backpressure: every valid cycle in RUN is consumed; start is ignored while running.
module miter_seq_checker import miter_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic                clk,
  input logic                rst,
  miter_seq_checker_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ffi_q, ffi_d;
  logic [WIDTH-1:0] ffm_q, ffm_d;
  logic             fail_q, fail_d;
  logic [WIDTH-1:0] mm_mask;
  logic             mm_any;

  miter_cmp_vec #(.WIDTH(WIDTH)) u_cmp (
    .gold   (bus.in_gold),
    .gate   (bus.in_gate),
    .mask   (mm_mask),
    .any_mm (mm_any)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ffi_d   = ffi_q;
    ffm_d   = ffm_q;
    fail_d  = fail_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          idx_d   = '0;
          cnt_d   = '0;
          ffi_d   = '0;
          ffm_d   = '0;
          fail_d  = 1'b0;
        end
      end
      RUN: begin
        if (bus.valid) begin
          idx_d = idx_q + 1'b1;
          if (mm_any) begin
            fail_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            // Only the first mismatch of the run is captured.
            if (!fail_q) begin
              ffi_d = idx_q;
              ffm_d = mm_mask;
            end
          end
          if (idx_q == LAST_IDX) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      ffi_q   <= '0;
      ffm_q   <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ffi_q   <= ffi_d;
      ffm_q   <= ffm_d;
      fail_q  <= fail_d;
    end
  end

  assign bus.busy            = (state_q == RUN);
  assign bus.done            = (state_q == DONE);
  assign bus.pass            = (state_q == DONE) && !fail_q;
  assign bus.fail            = fail_q;
  assign bus.mismatch_count  = cnt_q;
  assign bus.first_fail_idx  = ffi_q;
  assign bus.first_fail_mask = ffm_q;

endmodule

// File: tb/tb_miter_seq_checker.sv
// Bench for miter_seq_checker: a DEPTH=4 instance driven from a run table with a
// result scoreboard, and a CNT_W=2/DEPTH=3 instance for back-to-back full-mismatch runs.
module tb_miter_seq_checker;
  import miter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  miter_seq_checker_if #(.WIDTH(4), .CNT_W(8)) ia ();
  miter_seq_checker_if #(.WIDTH(4), .CNT_W(2)) ib ();

  miter_seq_checker #(.WIDTH(4), .DEPTH(4), .CNT_W(8)) u_a (.clk(clk), .rst(rst), .bus(ia));
  miter_seq_checker #(.WIDTH(4), .DEPTH(3), .CNT_W(2)) u_b (.clk(clk), .rst(rst), .bus(ib));

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] cnt;
    logic [7:0] idx;
    logic [3:0] mask;
    logic       pass;
  } res_t;

  typedef struct packed {
    logic [3:0][3:0] gold;
    logic [3:0][3:0] gate;
    res_t            exp;
  } run_t;

  res_t sb_q[$];
  run_t runs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference result of a 4-sample run using gold-X-is-don't-care semantics.
  function automatic res_t model(input logic [3:0][3:0] g, input logic [3:0][3:0] t);
    res_t r;
    logic [3:0] m;
    r = '0;
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 4; i++) m[i] = (g[s][i] !== 1'bx) && (g[s][i] !== t[s][i]);
      if (m != 4'h0) begin
        if (r.cnt == 8'd0) begin
          r.idx  = 8'(s);
          r.mask = m;
        end
        r.cnt = r.cnt + 8'd1;
      end
    end
    r.pass = (r.cnt == 8'd0);
    return r;
  endfunction

  task automatic cyc_a(input logic r, input logic s, input logic v,
                       input logic [3:0] g, input logic [3:0] t);
    @(negedge clk);
    rst = r; ia.start = s; ia.valid = v; ia.in_gold = g; ia.in_gate = t;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_b(input logic s, input logic v, input logic [3:0] g, input logic [3:0] t);
    @(negedge clk);
    rst = 1'b0; ib.start = s; ib.valid = v; ib.in_gold = g; ib.in_gate = t;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard pop on each rising done of instance A.
  logic done_a_prev = 1'b0;
  always @(negedge clk) begin : mon
    res_t e;
    if (ia.done && !done_a_prev) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_done: got done=1 want no pending run");
      end else begin
        e = sb_q.pop_front();
        chk("run_count", 32'(ia.mismatch_count), 32'(e.cnt));
        chk("run_first_idx", 32'(ia.first_fail_idx), 32'(e.idx));
        chk("run_first_mask", 32'(ia.first_fail_mask), 32'(e.mask));
        chk("run_pass", 32'(ia.pass), 32'(e.pass));
        chk("run_fail", 32'(ia.fail), 32'(!e.pass));
      end
    end
    done_a_prev = ia.done;
  end

  initial begin
    rst = 1'b1;
    ia.start = 1'b0; ia.valid = 1'b0; ia.in_gold = '0; ia.in_gate = '0;
    ib.start = 1'b0; ib.valid = 1'b0; ib.in_gold = '0; ib.in_gate = '0;

    runs[0].gold = {4'hA, 4'hA, 4'hA, 4'hA};
    runs[0].gate = {4'hA, 4'hA, 4'hA, 4'hA};
    runs[0].exp  = '{cnt: 8'd0, idx: 8'd0, mask: 4'h0, pass: 1'b1};
    runs[1].gold = {4'b0001, 4'b1010, 4'h3, 4'h5};
    runs[1].gate = {4'b0000, 4'b1000, 4'h3, 4'h5};
    runs[1].exp  = '{cnt: 8'd2, idx: 8'd2, mask: 4'b0010, pass: 1'b0};
    runs[2].gold = {4{4'b1x0x}};
    runs[2].gate = {4{4'b1101}};
    runs[2].exp  = model(runs[2].gold, runs[2].gate);
    runs[3].gold = {4'h8, 4'h9, 4'h6, 4'hF};
    runs[3].gate = {4'h0, 4'h9, 4'h6, 4'h0};
    runs[3].exp  = '{cnt: 8'd2, idx: 8'd0, mask: 4'hF, pass: 1'b0};

    cyc_a(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    cyc_a(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("rst_busy", 32'(ia.busy), 0);
    chk("rst_done", 32'(ia.done), 0);
    chk("rst_pass", 32'(ia.pass), 0);
    chk("rst_fail", 32'(ia.fail), 0);
    chk("rst_count", 32'(ia.mismatch_count), 0);
    chk("rst_idx", 32'(ia.first_fail_idx), 0);
    chk("rst_mask", 32'(ia.first_fail_mask), 0);
    chk("rst_b_busy", 32'(ib.busy), 0);

    for (int r = 0; r < 4; r++) begin
      cyc_a(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
      chk("start_busy", 32'(ia.busy), 1);
      chk("start_clr_count", 32'(ia.mismatch_count), 0);
      chk("start_clr_fail", 32'(ia.fail), 0);
      for (int s = 0; s < 4; s++) begin
        // Idle gaps carry start and mismatching data; neither may be consumed.
        for (int k = 0; k < int'($urandom_range(0, 2)); k++)
          cyc_a(1'b0, 1'b1, 1'b0, 4'hF, 4'h0);
        if (s == 3) sb_q.push_back(runs[r].exp);
        cyc_a(1'b0, 1'b0, 1'b1, runs[r].gold[s], runs[r].gate[s]);
        if (s < 3) begin
          chk("mid_busy", 32'(ia.busy), 1);
          chk("mid_done", 32'(ia.done), 0);
        end else begin
          chk("last_done", 32'(ia.done), 1);
          chk("last_busy", 32'(ia.busy), 0);
        end
        if (r == 1) chk("sticky_fail", 32'(ia.fail), 32'(s >= 2));
      end
      cyc_a(1'b0, 1'b0, 1'b1, 4'hF, 4'h0);
      chk("hold_done", 32'(ia.done), 1);
      chk("hold_count", 32'(ia.mismatch_count), 32'(runs[r].exp.cnt));
    end

    // Reset mid-run, with start and a mismatching sample on the same edge.
    cyc_a(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    cyc_a(1'b0, 1'b0, 1'b1, 4'h1, 4'h0);
    chk("pre_rst_fail", 32'(ia.fail), 1);
    chk("pre_rst_count", 32'(ia.mismatch_count), 1);
    cyc_a(1'b0, 1'b1, 1'b0, 4'h1, 4'h0);
    cyc_a(1'b0, 1'b0, 1'b1, 4'h3, 4'h3);
    chk("pre_rst_count2", 32'(ia.mismatch_count), 1);
    cyc_a(1'b1, 1'b1, 1'b1, 4'h1, 4'h0);
    chk("mid_rst_busy", 32'(ia.busy), 0);
    chk("mid_rst_done", 32'(ia.done), 0);
    chk("mid_rst_fail", 32'(ia.fail), 0);
    chk("mid_rst_count", 32'(ia.mismatch_count), 0);
    chk("mid_rst_mask", 32'(ia.first_fail_mask), 0);
    cyc_a(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("rst_start_ignored", 32'(ia.busy), 0);
    cyc_a(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    for (int s = 0; s < 4; s++) begin
      if (s == 3) sb_q.push_back('{cnt: 8'd0, idx: 8'd0, mask: 4'h0, pass: 1'b1});
      cyc_a(1'b0, 1'b0, 1'b1, 4'h6, 4'h6);
      chk("post_rst_done", 32'(ia.done), 32'(s == 3));
    end
    cyc_a(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

    // Back-to-back all-mismatch runs on the narrow-counter instance.
    for (int r = 0; r < 2; r++) begin
      cyc_b(1'b1, 1'b0, 4'h0, 4'h0);
      chk("b_start_busy", 32'(ib.busy), 1);
      chk("b_clr_count", 32'(ib.mismatch_count), 0);
      chk("b_clr_fail", 32'(ib.fail), 0);
      for (int s = 0; s < 3; s++) begin
        if (s == 1) cyc_b(1'b1, 1'b0, 4'hF, 4'h0);
        cyc_b(1'b0, 1'b1, 4'hF, 4'h0);
        chk("b_count", 32'(ib.mismatch_count), 32'(s + 1));
      end
      chk("b_done", 32'(ib.done), 1);
      chk("b_pass", 32'(ib.pass), 0);
      chk("b_fail", 32'(ib.fail), 1);
      chk("b_first_idx", 32'(ib.first_fail_idx), 0);
      chk("b_first_mask", 32'(ib.first_fail_mask), 32'hF);
    end

    cyc_b(1'b0, 1'b0, 4'h0, 4'h0);
    cyc_b(1'b0, 1'b0, 4'h0, 4'h0);
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
